// File: rtl/reg_file.sv
// reg_file: 32 x XLEN RV32I integer register file for the single-cycle core.
//   clk, rst_n          : core clock; asynchronous active-low reset
//   rs1_addr/rs1_data   : read port 1, combinational (optional write-first bypass)
//   rs2_addr/rs2_data   : read port 2, combinational (optional write-first bypass)
//   wr_en/wr_addr/wr_data : synchronous write port, x0 writes are dropped
//   dbg_addr/dbg_data   : debug read port, combinational, never bypassed
// x0 has no storage. x2 (sp) resets to SP_RESET and every other register resets to 0.

// One read port. rf[0] is tied to zero by the parent, but addr 0 is also
// forced to zero here so that a bypass can never leak onto x0.
module reg_file_rd_port #(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic [31:0][XLEN-1:0] rf,
  input  logic [4:0]            addr,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic [XLEN-1:0]       data
);
  always_comb begin
    data = rf[addr];
    if (addr == 5'd0)                              data = '0;
    else if (BYPASS && wr_en && (wr_addr == addr)) data = wr_data;
  end
endmodule

module reg_file #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] SP_RESET = '0,
  parameter int              BYPASS   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  // Ports 0/1 are rs1/rs2, port 2 is debug.
  localparam int NUM_PORTS = 3;

  logic [31:1][XLEN-1:0]          regs;
  logic [31:0][XLEN-1:0]          rf;
  logic                           wr_live;
  logic [NUM_PORTS-1:0][4:0]      rd_addr;
  logic [NUM_PORTS-1:0][XLEN-1:0] rd_data;

  // 32-entry view with x0 hard-wired, so the full 5-bit address decodes.
  assign rf = {regs, {XLEN{1'b0}}};

  // The write is dead while reset is held, so the bypass path must also see it
  // as dead; otherwise reads would show the lost write instead of the reset state.
  assign wr_live = wr_en & rst_n;

  assign rd_addr  = {dbg_addr, rs2_addr, rs1_addr};
  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];
  assign dbg_data = rd_data[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= (i == 2) ? SP_RESET : '0;
    end else begin
      // Index 0 is never visited, so an x0 write falls through.
      for (int i = 1; i < 32; i++)
        if (wr_en && (wr_addr == 5'(i))) regs[i] <= wr_data;
    end
  end

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
      reg_file_rd_port #(
        .XLEN  (XLEN),
        .BYPASS((BYPASS != 0) && (g < 2))
      ) u_rd (
        .rf     (rf),
        .addr   (rd_addr[g]),
        .wr_en  (wr_live),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .data   (rd_data[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
  localparam logic [31:0] SP = 32'h0000_3FFC;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, dbg_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] r0_rs1, r0_rs2, r0_dbg;   // BYPASS = 0
  logic [31:0] r1_rs1, r1_rs2, r1_dbg;   // BYPASS = 1

  sb_t         sb[$];
  sb_t         e;
  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  reg_file #(.XLEN(32), .SP_RESET(SP), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(r0_rs1), .rs2_data(r0_rs2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(r0_dbg));

  reg_file #(.XLEN(32), .SP_RESET(SP), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(r1_rs1), .rs2_data(r1_rs2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(r1_dbg));

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Write one register on the next rising edge, then drop wr_en.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2;
    dbg_addr = 5'd2; rs1_addr = 5'd2; rs2_addr = 5'd0;
    rst_n = 1'b0;                       // mid-cycle, no edge before the check
    sb.push_back('{"rst_async_dbg2", SP});
    sb.push_back('{"rst_async_rs1_2", SP});
    sb.push_back('{"rst_async_rs2_0", 32'h0});
    #1;
    e = sb.pop_front(); ntests++;
    if (r0_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_dbg, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r1_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_rs1, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r0_rs2 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs2, e.exp); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      sb.push_back('{$sformatf("rst_sweep_x%0d", i), (i == 2) ? SP : 32'h0});
      #1;
      e = sb.pop_front(); ntests++;
      if (r0_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_dbg, e.exp); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    logic [31:0] sra;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h8000_0001;
    @(negedge clk);
    wr_addr = 5'd31; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_en = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd31;
    sb.push_back('{"wr_rs1_x5", 32'h8000_0001});
    sb.push_back('{"wr_rs2_x31", 32'hDEAD_BEEF});
    sb.push_back('{"wr_sra4_x5", 32'hF800_0000});
    #1;
    e = sb.pop_front(); ntests++;
    if (r0_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs1, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r1_rs2 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_rs2, e.exp); end
    sra = $signed(r0_rs1) >>> 4;
    e = sb.pop_front(); ntests++;
    if (sra !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, sra, e.exp); end
  endtask

  task automatic test_x0;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
    sb.push_back('{"x0_bypass_rs1", 32'h0});
    #1;
    e = sb.pop_front(); ntests++;
    if (r1_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_rs1, e.exp); end
    @(negedge clk);
    wr_en = 1'b0;
    sb.push_back('{"x0_rs1", 32'h0});
    sb.push_back('{"x0_rs2", 32'h0});
    sb.push_back('{"x0_dbg", 32'h0});
    #1;
    e = sb.pop_front(); ntests++;
    if (r0_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs1, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r1_rs2 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_rs2, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r0_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_dbg, e.exp); end
  endtask

  task automatic test_read_during_write;
    do_write(5'd7, 32'h1111_1111);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2222_2222;
    rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7;
    sb.push_back('{"rdw_nobyp_rs1_pre", 32'h1111_1111});
    sb.push_back('{"rdw_byp_rs1_pre", 32'h2222_2222});
    sb.push_back('{"rdw_byp_rs2_pre", 32'h2222_2222});
    sb.push_back('{"rdw_nobyp_dbg_pre", 32'h1111_1111});
    sb.push_back('{"rdw_byp_dbg_pre", 32'h1111_1111});
    #1;
    e = sb.pop_front(); ntests++;
    if (r0_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs1, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r1_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_rs1, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r1_rs2 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_rs2, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r0_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_dbg, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r1_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_dbg, e.exp); end
    @(posedge clk);
    sb.push_back('{"rdw_nobyp_rs1_post", 32'h2222_2222});
    sb.push_back('{"rdw_nobyp_dbg_post", 32'h2222_2222});
    #1;
    e = sb.pop_front(); ntests++;
    if (r0_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs1, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r0_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_dbg, e.exp); end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_hold;
    do_write(5'd9, 32'h0000_0909);
    wr_en = 1'b0; wr_addr = 5'd9; wr_data = 32'hABCD_0123; rs1_addr = 5'd9; dbg_addr = 5'd9;
    sb.push_back('{"hold_byp_rs1_pre", 32'h0000_0909});
    #1;
    e = sb.pop_front(); ntests++;
    if (r1_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_rs1, e.exp); end
    repeat (3) @(posedge clk);
    sb.push_back('{"hold_rs1_x9", 32'h0000_0909});
    sb.push_back('{"hold_dbg_x9", 32'h0000_0909});
    #1;
    e = sb.pop_front(); ntests++;
    if (r0_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs1, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r1_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_dbg, e.exp); end
  endtask

  task automatic test_reset_during_write;
    do_write(5'd3, 32'h5);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234; dbg_addr = 5'd3; rs1_addr = 5'd3;
    @(posedge clk);
    rst_n = 1'b0;                       // coincident with the write edge
    sb.push_back('{"rstwr_dbg_in_reset", 32'h0});
    #1;
    e = sb.pop_front(); ntests++;
    if (r0_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_dbg, e.exp); end
    @(negedge clk);
    wr_en = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    rs2_addr = 5'd5;
    sb.push_back('{"rstwr_rs1_x3", 32'h0});
    sb.push_back('{"rstwr_dbg_x3", 32'h0});
    sb.push_back('{"rstwr_rs2_x5_cleared", 32'h0});
    #1;
    e = sb.pop_front(); ntests++;
    if (r0_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs1, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r1_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_dbg, e.exp); end
    e = sb.pop_front(); ntests++;
    if (r0_rs2 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs2, e.exp); end
  endtask

  // Random writes on consecutive edges, then a full sweep against the model.
  task automatic test_back_to_back;
    for (int i = 0; i < 32; i++) model[i] = (i == 2) ? SP : 32'h0;
    @(negedge clk);
    wr_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      if (wr_addr != 5'd0) model[wr_addr] = wr_data;
      @(negedge clk);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); dbg_addr = 5'(i);
      sb.push_back('{$sformatf("b2b_rs1_x%0d", i), model[i]});
      sb.push_back('{$sformatf("b2b_rs2_x%0d", 31 - i), model[31 - i]});
      sb.push_back('{$sformatf("b2b_dbg_x%0d", i), model[i]});
      sb.push_back('{$sformatf("b2b_byp_rs1_x%0d", i), model[i]});
      #1;
      e = sb.pop_front(); ntests++;
      if (r0_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs1, e.exp); end
      e = sb.pop_front(); ntests++;
      if (r0_rs2 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_rs2, e.exp); end
      e = sb.pop_front(); ntests++;
      if (r0_dbg !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r0_dbg, e.exp); end
      e = sb.pop_front(); ntests++;
      if (r1_rs1 !== e.exp) begin nfail++; $display("FAIL %s: got %h expected %h", e.name, r1_rs1, e.exp); end
    end
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    test_reset;
    test_write_read;
    test_x0;
    test_read_during_write;
    test_hold;
    test_reset_during_write;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
